mask_centroid: RTL and testbench



---
 rtl/mask_centroid.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_mask_centroid.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mask_centroid.sv
// mask_centroid: accumulates the masked-pixel count and the x/y coordinate sums
// over a frame. At frame end it divides each sum by the count with two parallel
// restoring dividers and reports the centroid.
//
// Optional feature: define MASK_CENTROID_BBOX_EN to add per-frame bounding-box
// outputs (bbox_xmin/xmax, bbox_ymin/ymax).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_in, mask_in pixel valid and mask bit for this pixel
//   x_in, y_in        coordinates of this pixel
//   frame_done        pulse marking the last pixel of a frame
//   busy              dividers running
//   valid_out         single-cycle pulse when the results update
//   x_out, y_out      centroid (floored mean)
//   count_out, empty  masked-pixel count of the reported frame, zero-count flag
//   overrun           sticky; frame_done arrived while a result was pending
module mask_centroid #(
   parameter int unsigned H_BITS   = 11,
   parameter int unsigned V_BITS   = 10,
   parameter int unsigned CNT_BITS = 21,
   parameter int unsigned SUM_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_in,
   input  logic                mask_in,
   input  logic [H_BITS-1:0]   x_in,
   input  logic [V_BITS-1:0]   y_in,
   input  logic                frame_done,
`ifdef MASK_CENTROID_BBOX_EN
   output logic [H_BITS-1:0]   bbox_xmin,
   output logic [H_BITS-1:0]   bbox_xmax,
   output logic [V_BITS-1:0]   bbox_ymin,
   output logic [V_BITS-1:0]   bbox_ymax,
`endif
   output logic                busy,
   output logic                valid_out,
   output logic [H_BITS-1:0]   x_out,
   output logic [V_BITS-1:0]   y_out,
   output logic [CNT_BITS-1:0] count_out,
   output logic                empty,
   output logic                overrun
);

   localparam int unsigned REM_W  = SUM_BITS + 1;
   localparam int unsigned STEP_W = $clog2(SUM_BITS);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [CNT_BITS-1:0] acc_cnt_q, acc_cnt_d, div_q, div_d;
   logic [SUM_BITS-1:0] acc_sx_q, acc_sx_d, acc_sy_q, acc_sy_d;
   logic [SUM_BITS-1:0] quo_x_q, quo_x_d, quo_y_q, quo_y_d;
   logic [REM_W-1:0]    rem_x_q, rem_x_d, rem_y_q, rem_y_d;
   logic                busy_q, busy_d, valid_q, valid_d, empty_q, empty_d;
   logic                overrun_q, overrun_d;
   logic [H_BITS-1:0]   x_q, x_d;
   logic [V_BITS-1:0]   y_q, y_d;
   logic [CNT_BITS-1:0] count_q, count_d;

   // Accumulator values with the current pixel folded in (saturating)
   logic                pix_hit;
   logic [CNT_BITS-1:0] cnt_inc;
   logic [REM_W-1:0]    sx_wide, sy_wide;
   logic [SUM_BITS-1:0] sx_inc, sy_inc;

`ifdef MASK_CENTROID_BBOX_EN
   logic [H_BITS-1:0] trk_xmin_q, trk_xmin_d, trk_xmax_q, trk_xmax_d;
   logic [V_BITS-1:0] trk_ymin_q, trk_ymin_d, trk_ymax_q, trk_ymax_d;
   logic [H_BITS-1:0] snp_xmin_q, snp_xmin_d, snp_xmax_q, snp_xmax_d;
   logic [V_BITS-1:0] snp_ymin_q, snp_ymin_d, snp_ymax_q, snp_ymax_d;
   logic [H_BITS-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d;
   logic [V_BITS-1:0] bymin_q, bymin_d, bymax_q, bymax_d;
   logic [H_BITS-1:0] xmin_inc, xmax_inc;
   logic [V_BITS-1:0] ymin_inc, ymax_inc;
`endif

   // One restoring-division step: returns {remainder, shifted dividend/quotient}
   function automatic logic [REM_W+SUM_BITS-1:0] div_step(
      input logic [REM_W-1:0]    rem,
      input logic [SUM_BITS-1:0] quo,
      input logic [CNT_BITS-1:0] d
   );
      logic [REM_W-1:0] sh;
      logic [REM_W-1:0] dw;
      sh = {rem[SUM_BITS-1:0], quo[SUM_BITS-1]};
      dw = REM_W'(d);
      if (sh >= dw) return {sh - dw, quo[SUM_BITS-2:0], 1'b1};
      else          return {sh, quo[SUM_BITS-2:0], 1'b0};
   endfunction

   // Accumulator increment for the pixel presented this cycle
   always_comb begin
      pix_hit = valid_in & mask_in;
      cnt_inc = acc_cnt_q;
      if (pix_hit && (acc_cnt_q != '1)) cnt_inc = acc_cnt_q + CNT_BITS'(1);
      sx_wide = {1'b0, acc_sx_q} + REM_W'(x_in);
      sy_wide = {1'b0, acc_sy_q} + REM_W'(y_in);
      sx_inc  = acc_sx_q;
      sy_inc  = acc_sy_q;
      if (pix_hit) begin
         sx_inc = sx_wide[SUM_BITS] ? '1 : sx_wide[SUM_BITS-1:0];
         sy_inc = sy_wide[SUM_BITS] ? '1 : sy_wide[SUM_BITS-1:0];
      end
`ifdef MASK_CENTROID_BBOX_EN
      xmin_inc = trk_xmin_q;
      xmax_inc = trk_xmax_q;
      ymin_inc = trk_ymin_q;
      ymax_inc = trk_ymax_q;
      if (pix_hit) begin
         if (x_in < trk_xmin_q) xmin_inc = x_in;
         if (x_in > trk_xmax_q) xmax_inc = x_in;
         if (y_in < trk_ymin_q) ymin_inc = y_in;
         if (y_in > trk_ymax_q) ymax_inc = y_in;
      end
`endif
   end

   // Next-state, accumulator, divider and output logic
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      div_d     = div_q;
      quo_x_d   = quo_x_q;
      quo_y_d   = quo_y_q;
      rem_x_d   = rem_x_q;
      rem_y_d   = rem_y_q;
      valid_d   = 1'b0;
      empty_d   = empty_q;
      overrun_d = overrun_q;
      x_d       = x_q;
      y_d       = y_q;
      count_d   = count_q;
      acc_cnt_d = cnt_inc;
      acc_sx_d  = sx_inc;
      acc_sy_d  = sy_inc;
`ifdef MASK_CENTROID_BBOX_EN
      trk_xmin_d = xmin_inc;
      trk_xmax_d = xmax_inc;
      trk_ymin_d = ymin_inc;
      trk_ymax_d = ymax_inc;
      snp_xmin_d = snp_xmin_q;
      snp_xmax_d = snp_xmax_q;
      snp_ymin_d = snp_ymin_q;
      snp_ymax_d = snp_ymax_q;
      bxmin_d    = bxmin_q;
      bxmax_d    = bxmax_q;
      bymin_d    = bymin_q;
      bymax_d    = bymax_q;
`endif

      // Frame end always clears the accumulators, whatever the FSM does
      if (frame_done) begin
         acc_cnt_d = '0;
         acc_sx_d  = '0;
         acc_sy_d  = '0;
`ifdef MASK_CENTROID_BBOX_EN
         trk_xmin_d = '1;
         trk_xmax_d = '0;
         trk_ymin_d = '1;
         trk_ymax_d = '0;
`endif
      end

      case (state_q)
         S_IDLE: begin
            if (frame_done) begin
               div_d   = cnt_inc;
               quo_x_d = sx_inc;
               quo_y_d = sy_inc;
               rem_x_d = '0;
               rem_y_d = '0;
               step_d  = '0;
`ifdef MASK_CENTROID_BBOX_EN
               snp_xmin_d = xmin_inc;
               snp_xmax_d = xmax_inc;
               snp_ymin_d = ymin_inc;
               snp_ymax_d = ymax_inc;
`endif
               state_d = (cnt_inc == '0) ? S_DONE : S_DIV;
            end
         end
         S_DIV: begin
            {rem_x_d, quo_x_d} = div_step(rem_x_q, quo_x_q, div_q);
            {rem_y_d, quo_y_d} = div_step(rem_y_q, quo_y_q, div_q);
            step_d = step_q + STEP_W'(1);
            if (step_q == LAST_STEP) state_d = S_DONE;
            if (frame_done) overrun_d = 1'b1;
         end
         S_DONE: begin
            valid_d = 1'b1;
            count_d = div_q;
            empty_d = (div_q == '0);
            // Mean never exceeds the largest coordinate, so truncation is lossless
            if (div_q != '0) begin
               x_d = H_BITS'(quo_x_q);
               y_d = V_BITS'(quo_y_q);
            end
`ifdef MASK_CENTROID_BBOX_EN
            bxmin_d = snp_xmin_q;
            bxmax_d = snp_xmax_q;
            bymin_d = snp_ymin_q;
            bymax_d = snp_ymax_q;
`endif
            if (frame_done) overrun_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_DIV);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         step_q    <= '0;
         div_q     <= '0;
         quo_x_q   <= '0;
         quo_y_q   <= '0;
         rem_x_q   <= '0;
         rem_y_q   <= '0;
         acc_cnt_q <= '0;
         acc_sx_q  <= '0;
         acc_sy_q  <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         empty_q   <= 1'b0;
         overrun_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         count_q   <= '0;
`ifdef MASK_CENTROID_BBOX_EN
         // Trackers start at their neutral values so the first frame is correct
         trk_xmin_q <= '1;
         trk_xmax_q <= '0;
         trk_ymin_q <= '1;
         trk_ymax_q <= '0;
         snp_xmin_q <= '0;
         snp_xmax_q <= '0;
         snp_ymin_q <= '0;
         snp_ymax_q <= '0;
         bxmin_q    <= '0;
         bxmax_q    <= '0;
         bymin_q    <= '0;
         bymax_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         div_q     <= div_d;
         quo_x_q   <= quo_x_d;
         quo_y_q   <= quo_y_d;
         rem_x_q   <= rem_x_d;
         rem_y_q   <= rem_y_d;
         acc_cnt_q <= acc_cnt_d;
         acc_sx_q  <= acc_sx_d;
         acc_sy_q  <= acc_sy_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         empty_q   <= empty_d;
         overrun_q <= overrun_d;
         x_q       <= x_d;
         y_q       <= y_d;
         count_q   <= count_d;
`ifdef MASK_CENTROID_BBOX_EN
         trk_xmin_q <= trk_xmin_d;
         trk_xmax_q <= trk_xmax_d;
         trk_ymin_q <= trk_ymin_d;
         trk_ymax_q <= trk_ymax_d;
         snp_xmin_q <= snp_xmin_d;
         snp_xmax_q <= snp_xmax_d;
         snp_ymin_q <= snp_ymin_d;
         snp_ymax_q <= snp_ymax_d;
         bxmin_q    <= bxmin_d;
         bxmax_q    <= bxmax_d;
         bymin_q    <= bymin_d;
         bymax_q    <= bymax_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign valid_out = valid_q;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign count_out = count_q;
   assign empty     = empty_q;
   assign overrun   = overrun_q;
`ifdef MASK_CENTROID_BBOX_EN
   assign bbox_xmin = bxmin_q;
   assign bbox_xmax = bxmax_q;
   assign bbox_ymin = bymin_q;
   assign bbox_ymax = bymax_q;
`endif

endmodule

// File: tb/tb_mask_centroid.sv
// Directed bench for mask_centroid with a scoreboard of expected results.
module tb_mask_centroid;

   localparam int unsigned H_BITS   = 11;
   localparam int unsigned V_BITS   = 10;
   localparam int unsigned CNT_BITS = 21;
   localparam int unsigned SUM_BITS = 32;
   localparam int          LAT_DIV  = SUM_BITS + 2;

   logic                clk, rst_n, valid_in, mask_in, frame_done;
   logic [H_BITS-1:0]   x_in;
   logic [V_BITS-1:0]   y_in;
   logic                busy, valid_out, empty, overrun;
   logic [H_BITS-1:0]   x_out;
   logic [V_BITS-1:0]   y_out;
   logic [CNT_BITS-1:0] count_out;
`ifdef MASK_CENTROID_BBOX_EN
   logic [H_BITS-1:0]   bbox_xmin, bbox_xmax;
   logic [V_BITS-1:0]   bbox_ymin, bbox_ymax;
`endif

   mask_centroid #(
      .H_BITS(H_BITS), .V_BITS(V_BITS), .CNT_BITS(CNT_BITS), .SUM_BITS(SUM_BITS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mask_in(mask_in),
      .x_in(x_in), .y_in(y_in), .frame_done(frame_done),
`ifdef MASK_CENTROID_BBOX_EN
      .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
      .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
`endif
      .busy(busy), .valid_out(valid_out), .x_out(x_out), .y_out(y_out),
      .count_out(count_out), .empty(empty), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int c;
      int e;
      int lat;
      int fdc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic pix(input int px, input int py, input bit m);
      valid_in = 1'b1;
      mask_in  = m;
      x_in     = H_BITS'(px);
      y_in     = V_BITS'(py);
      tick();
      valid_in = 1'b0;
      mask_in  = 1'b0;
   endtask

   // Pulse frame_done (optionally with a masked pixel); push expectation if requested
   task automatic fd(input bit with_pix, input int px, input int py, input bit push,
                     input int ex, input int ey, input int ec, input int ee, input int elat);
      exp_t e;
      frame_done = 1'b1;
      if (with_pix) begin
         valid_in = 1'b1;
         mask_in  = 1'b1;
         x_in     = H_BITS'(px);
         y_in     = V_BITS'(py);
      end
      if (push) begin
         e.x = ex; e.y = ey; e.c = ec; e.e = ee; e.lat = elat; e.fdc = cyc;
         sb.push_back(e);
      end
      tick();
      frame_done = 1'b0;
      valid_in   = 1'b0;
      mask_in    = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (valid_out !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         chk({tag, "_timeout"}, 32'(valid_out), 32'd1);
      end else begin
         chk({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(cyc - e.fdc), 32'(e.lat));
            chk({tag, "_x"}, 32'(x_out), 32'(e.x));
            chk({tag, "_y"}, 32'(y_out), 32'(e.y));
            chk({tag, "_count"}, 32'(count_out), 32'(e.c));
            chk({tag, "_empty"}, 32'(empty), 32'(e.e));
         end
         tick();
         chk({tag, "_pulse_once"}, 32'(valid_out), 32'd0);
      end
   endtask

   initial begin
      int nvalid;
      rst_n = 1'b0; valid_in = 1'b0; mask_in = 1'b0; frame_done = 1'b0;
      x_in = '0; y_in = '0;
      repeat (3) tick();
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_x", 32'(x_out), 32'd0);
      chk("rst_y", 32'(y_out), 32'd0);
      chk("rst_count", 32'(count_out), 32'd0);
      chk("rst_empty", 32'(empty), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      #2 rst_n = 1'b1;
      tick();

      // Single pixel
      pix(100, 50, 1'b1);
      fd(1'b0, 0, 0, 1'b1, 100, 50, 1, 0, LAT_DIV);
      tick();
      chk("single_busy", 32'(busy), 32'd1);
      wait_result("single");

      // Empty frame holds previous centroid
      pix(600, 600, 1'b0);
      fd(1'b0, 0, 0, 1'b1, 100, 50, 0, 1, 2);
      wait_result("empty");

      // Four masked plus six unmasked pixels
      pix(10, 20, 1'b1); pix(500, 500, 1'b0); pix(11, 20, 1'b1);
      pix(0, 0, 1'b0);   pix(2047, 1023, 1'b0); pix(10, 21, 1'b1);
      pix(3, 3, 1'b0);   pix(900, 7, 1'b0);   pix(11, 21, 1'b1);
      pix(1, 999, 1'b0);
      fd(1'b0, 0, 0, 1'b1, 10, 20, 4, 0, LAT_DIV);
      wait_result("four");

      // Maximum coordinates
      pix(2047, 1023, 1'b1);
      fd(1'b0, 0, 0, 1'b1, 2047, 1023, 1, 0, LAT_DIV);
      wait_result("maxcoord");

      // Overrun: pixel on the frame_done cycle belongs to the ending frame
      chk("overrun_before", 32'(overrun), 32'd0);
      fd(1'b1, 200, 100, 1'b1, 200, 100, 1, 0, LAT_DIV);
      repeat (4) pix(7, 7, 1'b1);
      fd(1'b1, 7, 7, 1'b0, 0, 0, 0, 0, 0);
      chk("overrun_set", 32'(overrun), 32'd1);
      wait_result("overrun_first");
      pix(30, 40, 1'b1);
      pix(32, 40, 1'b1);
      fd(1'b0, 0, 0, 1'b1, 31, 40, 2, 0, LAT_DIV);
      wait_result("after_overrun");
      chk("overrun_sticky", 32'(overrun), 32'd1);

      // Reset in the middle of a division
      pix(123, 45, 1'b1);
      fd(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
      repeat (10) tick();
      chk("middiv_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_x", 32'(x_out), 32'd0);
      chk("abort_y", 32'(y_out), 32'd0);
      chk("abort_count", 32'(count_out), 32'd0);
      chk("abort_overrun", 32'(overrun), 32'd0);
      tick();
      #2 rst_n = 1'b1;
      nvalid = 0;
      repeat (40) begin
         tick();
         if (valid_out === 1'b1) nvalid++;
      end
      chk("abort_no_valid", 32'(nvalid), 32'd0);
      pix(400, 300, 1'b1);
      pix(402, 301, 1'b1);
      fd(1'b0, 0, 0, 1'b1, 401, 300, 2, 0, LAT_DIV);
      wait_result("after_abort");

`ifdef MASK_CENTROID_BBOX_EN
      pix(5, 7, 1'b1);
      pix(300, 2, 1'b1);
      pix(40, 900, 1'b1);
      fd(1'b0, 0, 0, 1'b1, 115, 303, 3, 0, LAT_DIV);
      wait_result("bbox");
      chk("bbox_xmin", 32'(bbox_xmin), 32'd5);
      chk("bbox_xmax", 32'(bbox_xmax), 32'd300);
      chk("bbox_ymin", 32'(bbox_ymin), 32'd2);
      chk("bbox_ymax", 32'(bbox_ymax), 32'd900);
`endif

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
